// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with built-in test patterns or external pixel pass-through.
// Latency: de/hs/vs/rgb/frame_start appear 2 cycles after the counter position; x/y/req are combinational.
// Backpressure: none; the external source must answer every req one cycle later, with no stalls.
module video_timing_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 8,
  parameter int CHECK_LOG2 = 5,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW        = $clog2(H_TOTAL),
  localparam int YW        = $clog2(V_TOTAL)
) (
  input  logic                   clk_25,
  input  logic                   reset_n,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  input  logic [3*COLOR_W-1:0]   pix_rgb,
  output logic                   req,
  output logic [XW-1:0]          x,
  output logic [YW-1:0]          y,
  output logic                   de,
  output logic                   hs,
  output logic                   vs,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b,
  output logic                   frame_start
);

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam int            HS_START = H_ACTIVE + H_FP;
  localparam int            HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int            VS_START = V_ACTIVE + V_FP;
  localparam int            VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int            BAR_W    = H_ACTIVE / 8;
  localparam int            RGB_W    = 3 * COLOR_W;

  logic [XW-1:0]    r_h;
  logic [YW-1:0]    r_v;
  logic [1:0]       r_mode_q;

  // stage 1: timing flags and generated pattern for the counter position
  logic             r_de1, r_hs1, r_vs1, r_fs1;
  logic [1:0]       r_mode1;
  logic [RGB_W-1:0] r_pat1;

  // stage 2: output registers
  logic             r_de, r_hs, r_vs, r_fs;
  logic [RGB_W-1:0] r_rgb;

  logic [31:0]      w_h32, w_v32, w_bar_q;
  logic             w_active, w_hsync, w_vsync, w_first, w_check_white;
  logic [2:0]       w_bar_idx;
  logic [1:0]       w_mode_eff;
  logic [RGB_W-1:0] w_pat;

  assign w_h32    = 32'(r_h);
  assign w_v32    = 32'(r_v);
  assign w_first  = (r_h == '0) && (r_v == '0);
  assign w_active = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
  assign w_hsync  = (w_h32 >= HS_START) && (w_h32 < HS_END);
  assign w_vsync  = (w_v32 >= VS_START) && (w_v32 < VS_END);

  // The frame's mode is taken at (0,0) so that pixel already uses the newly latched value.
  assign w_mode_eff = w_first ? mode : r_mode_q;

  assign w_bar_q       = w_h32 / BAR_W;
  assign w_bar_idx     = (w_bar_q > 32'd7) ? 3'd7 : w_bar_q[2:0];
  assign w_check_white = ~(w_h32[CHECK_LOG2] ^ w_v32[CHECK_LOG2]);

  assign x   = r_h;
  assign y   = r_v;
  assign req = w_active;

  // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to r=~i[1], g=~i[2], b=~i[0].
  always_comb begin
    w_pat = '0;
    case (w_mode_eff)
      2'd1:    w_pat = {{COLOR_W{~w_bar_idx[1]}}, {COLOR_W{~w_bar_idx[2]}}, {COLOR_W{~w_bar_idx[0]}}};
      2'd2:    w_pat = w_check_white ? '1 : '0;
      default: w_pat = '0;
    endcase
  end

  // Raster counters and per-frame mode latch.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_h      <= '0;
      r_v      <= '0;
      r_mode_q <= 2'd1;
    end else begin
      if (w_first) r_mode_q <= mode;
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Stage 1 register: timing flags, mode and generated pattern, in step with the source's registered pixel.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_de1   <= 1'b0;
      r_hs1   <= 1'b0;
      r_vs1   <= 1'b0;
      r_fs1   <= 1'b0;
      r_mode1 <= 2'd1;
      r_pat1  <= '0;
    end else begin
      r_de1   <= w_active;
      r_hs1   <= w_hsync;
      r_vs1   <= w_vsync;
      r_fs1   <= w_first;
      r_mode1 <= w_mode_eff;
      r_pat1  <= w_pat;
    end
  end

  // Stage 2 register: select pixel source, blank outside the active area, apply sync polarity.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_de  <= 1'b0;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_fs  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_de <= r_de1;
      r_hs <= r_hs1 ? HS_POL : ~HS_POL;
      r_vs <= r_vs1 ? VS_POL : ~VS_POL;
      r_fs <= r_fs1;
      if (!r_de1)              r_rgb <= '0;
      else if (r_mode1 == 2'd0) r_rgb <= pix_rgb;
      else if (r_mode1 == 2'd3) r_rgb <= solid_rgb;
      else                      r_rgb <= r_pat1;
    end
  end

  assign de          = r_de;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign frame_start = r_fs;
  assign r           = r_rgb[3*COLOR_W-1:2*COLOR_W];
  assign g           = r_rgb[2*COLOR_W-1:COLOR_W];
  assign b           = r_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Directed bench: default-timing instance A and a small-timing instance B share clock and reset.
// Checks are placed at absolute cycle counts after reset release; output of position p appears at cycle p+2.
// The external source for A is a one-register model returning {x[7:0], y[7:0], 8'h5A}.
module tb_video_timing_pattern_gen;

  logic        clk_25 = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode_a = 2'd1;
  logic [1:0]  mode_b = 2'd2;
  logic [23:0] solid_rgb = 24'h123456;
  logic [23:0] pix_a = 24'h0;
  logic [23:0] pix_b = 24'hABCDEF;

  logic        req_a, de_a, hs_a, vs_a, fs_a;
  logic [9:0]  x_a, y_a;
  logic [7:0]  r_a, g_a, b_a;
  logic        req_b, de_b, hs_b, vs_b, fs_b;
  logic [6:0]  x_b;
  logic [2:0]  y_b;
  logic [7:0]  r_b, g_b, b_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #20 clk_25 = ~clk_25;

  video_timing_pattern_gen dut_a (
    .clk_25(clk_25), .reset_n(reset_n), .mode(mode_a), .solid_rgb(solid_rgb), .pix_rgb(pix_a),
    .req(req_a), .x(x_a), .y(y_a), .de(de_a), .hs(hs_a), .vs(vs_a),
    .r(r_a), .g(g_a), .b(b_a), .frame_start(fs_a)
  );

  video_timing_pattern_gen #(
    .H_ACTIVE(64), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)
  ) dut_b (
    .clk_25(clk_25), .reset_n(reset_n), .mode(mode_b), .solid_rgb(solid_rgb), .pix_rgb(pix_b),
    .req(req_b), .x(x_b), .y(y_b), .de(de_b), .hs(hs_b), .vs(vs_b),
    .r(r_b), .g(g_b), .b(b_b), .frame_start(fs_b)
  );

  // External frame source: one registered stage answering the current request.
  always @(posedge clk_25) pix_a <= {x_a[7:0], y_a[7:0], 8'h5A};

  // Clock edges since the last reset release.
  always @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int t);
    int guard = 0;
    while (cyc < t && guard < 100000) begin
      @(negedge clk_25);
      guard++;
    end
    if (cyc != t) begin
      errors++;
      $error("FAIL goto: observed cycle %0d expected %0d", cyc, t);
    end
  endtask

  initial begin
    // Reset state
    #30;
    chk("rst_de_a", 32'(de_a), 32'h0);
    chk("rst_hs_a", 32'(hs_a), 32'h1);
    chk("rst_vs_a", 32'(vs_a), 32'h1);
    chk("rst_rgb_a", 32'({r_a, g_a, b_a}), 32'h0);
    chk("rst_fs_a", 32'(fs_a), 32'h0);
    chk("rst_xy_a", 32'({x_a, y_a}), 32'h0);
    chk("rst_req_a", 32'(req_a), 32'h1);
    chk("rst_hs_b", 32'(hs_b), 32'h0);
    chk("rst_vs_b", 32'(vs_b), 32'h1);

    // Phase 1: A colour bars, B checkerboard then solid
    @(negedge clk_25);
    reset_n = 1'b1;
    goto(1);
    chk("c1_de_a", 32'(de_a), 32'h0);
    chk("c1_fs_a", 32'(fs_a), 32'h0);
    goto(2);
    chk("c2_fs_a", 32'(fs_a), 32'h1);
    chk("c2_de_a", 32'(de_a), 32'h1);
    chk("bar_x0", 32'({r_a, g_a, b_a}), 32'hFFFFFF);
    chk("c2_fs_b", 32'(fs_b), 32'h1);
    chk("chk_b_0_0", 32'({r_b, g_b, b_b}), 32'hFFFFFF);
    goto(3);
    chk("c3_fs_a", 32'(fs_a), 32'h0);
    goto(33);
    chk("chk_b_31_0", 32'({r_b, g_b, b_b}), 32'hFFFFFF);
    goto(34);
    chk("chk_b_32_0", 32'({r_b, g_b, b_b}), 32'h000000);
    chk("bar_x32", 32'({r_a, g_a, b_a}), 32'hFFFFFF);
    goto(65);
    chk("de_b_63", 32'(de_b), 32'h1);
    goto(66);
    chk("de_b_64", 32'(de_b), 32'h0);
    chk("blank_b_64", 32'({r_b, g_b, b_b}), 32'h0);
    goto(67);
    chk("hs_b_65", 32'(hs_b), 32'h0);
    goto(68);
    chk("hs_b_66", 32'(hs_b), 32'h1);
    goto(71);
    chk("hs_b_69", 32'(hs_b), 32'h1);
    goto(72);
    chk("hs_b_70", 32'(hs_b), 32'h0);
    chk("wrap_b_xy", 32'({x_b, y_b}), 32'({7'd0, 3'd1}));
    goto(81);
    chk("bar_x79", 32'({r_a, g_a, b_a}), 32'hFFFFFF);
    goto(82);
    chk("bar_x80", 32'({r_a, g_a, b_a}), 32'hFFFF00);
    goto(150);
    mode_b = 2'd3;
    goto(218);
    chk("chk_b_0_3", 32'({r_b, g_b, b_b}), 32'hFFFFFF);
    chk("cnt_b_218", 32'({x_b, y_b}), 32'({7'd2, 3'd3}));
    goto(290);
    chk("de_b_line4", 32'(de_b), 32'h0);
    goto(361);
    chk("vs_b_71_4", 32'(vs_b), 32'h1);
    goto(362);
    chk("vs_b_0_5", 32'(vs_b), 32'h0);
    goto(433);
    chk("vs_b_71_5", 32'(vs_b), 32'h0);
    goto(434);
    chk("vs_b_0_6", 32'(vs_b), 32'h1);
    goto(505);
    chk("fs_b_505", 32'(fs_b), 32'h0);
    goto(506);
    chk("fs_b_frame1", 32'(fs_b), 32'h1);
    chk("solid_b", 32'({r_b, g_b, b_b}), 32'h123456);
    goto(561);
    chk("bar_x559", 32'({r_a, g_a, b_a}), 32'h0000FF);
    goto(562);
    chk("bar_x560", 32'({r_a, g_a, b_a}), 32'h000000);
    goto(641);
    chk("de_a_639", 32'(de_a), 32'h1);
    chk("bar_x639", 32'({r_a, g_a, b_a}), 32'h000000);
    goto(642);
    chk("de_a_640", 32'(de_a), 32'h0);
    goto(657);
    chk("hs_a_655", 32'(hs_a), 32'h1);
    goto(658);
    chk("hs_a_656", 32'(hs_a), 32'h0);
    goto(753);
    chk("hs_a_751", 32'(hs_a), 32'h0);
    goto(754);
    chk("hs_a_752", 32'(hs_a), 32'h1);
    goto(802);
    chk("line1_de_a", 32'(de_a), 32'h1);
    chk("line1_rgb_a", 32'({r_a, g_a, b_a}), 32'hFFFFFF);
    chk("line1_fs_a", 32'(fs_a), 32'h0);

    // Mid-frame reset: outputs clear without waiting for a clock edge
    reset_n = 1'b0;
    mode_a  = 2'd0;
    #1;
    chk("mid_rst_de", 32'(de_a), 32'h0);
    chk("mid_rst_rgb", 32'({r_a, g_a, b_a}), 32'h0);
    chk("mid_rst_xy", 32'({x_a, y_a}), 32'h0);
    chk("mid_rst_hs", 32'(hs_a), 32'h1);

    // Phase 2: A external source
    @(negedge clk_25);
    reset_n = 1'b1;
    goto(2);
    chk("ph2_fs_a", 32'(fs_a), 32'h1);
    goto(1603);
    chk("ext_cnt", 32'({x_a, y_a}), 32'({10'd3, 10'd2}));
    chk("ext_req", 32'(req_a), 32'h1);
    goto(1604);
    chk("ext_2_2", 32'({r_a, g_a, b_a}), 32'h02025A);
    goto(1605);
    chk("ext_3_2", 32'({r_a, g_a, b_a}), 32'h03025A);
    goto(1606);
    chk("ext_4_2", 32'({r_a, g_a, b_a}), 32'h04025A);
    goto(2242);
    chk("ext_blank", 32'({r_a, g_a, b_a}), 32'h0);

    // Phase 3: A checkerboard
    reset_n = 1'b0;
    mode_a  = 2'd2;
    @(negedge clk_25);
    reset_n = 1'b1;
    goto(2);
    chk("chk_a_0_0", 32'({r_a, g_a, b_a}), 32'hFFFFFF);
    goto(34);
    chk("chk_a_32_0", 32'({r_a, g_a, b_a}), 32'h000000);
    goto(25602);
    chk("chk_a_0_32", 32'({r_a, g_a, b_a}), 32'h000000);
    goto(25634);
    chk("chk_a_32_32", 32'({r_a, g_a, b_a}), 32'hFFFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
